tx_envelope_sequencer: RTL and testbench
========================================

# tx_envelope_sequencer

Parametrised TX output stage between the CORDIC upconverter output and the DAC. It replaces hard on/off PTT gating with a four-state keying sequencer that applies a linear amplitude ramp to the carrier, avoiding key clicks. It saturates, rather than wraps, when narrowing to the DAC width, and drives the T/R indication and the heartbeat LED. One clock domain.

## Interface
- IN_WIDTH, 16: width of the signed RF sample from the CORDIC.
- DAC_WIDTH, 12: width of the signed DAC word.
- HEADROOM, 3: arithmetic right shift applied before saturation.
- RAMP_BITS, 8: gain resolution; full scale is 2^RAMP_BITS.
- RAMP_DIV, 16: clocks per gain step; must be ≥1.
- HANG_CYCLES, 4800: T/R hang length in clocks (used only with TX_HANG_EN).
- LED_FAST_BIT, 24 / LED_SLOW_BIT, 26: heartbeat counter taps.
- clk  in  1  sample clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- rf_in  in  IN_WIDTH  signed RF sample, valid every clock.
- ptt  in  1  phone/data key.
- cw_ptt  in  1  CW key.
- vna_mode  in  1  VNA sweep; forces full carrier with no ramp.
- dac_data  out  DAC_WIDTH  signed DAC word, registered.
- tx_active  out  1  T/R relay request.
- state  out  2  0=IDLE, 1=RAMP_UP, 2=ON, 3=RAMP_DOWN.
- gain  out  RAMP_BITS+1  current unsigned gain, 0..2^RAMP_BITS.
- led  out  1  heartbeat.

## Operation
- key = ptt | cw_ptt | vna_mode.
- Divider counts 0..RAMP_DIV-1. It is cleared on every state change. A gain step occurs on the cycle the divider is at RAMP_DIV-1.
- IDLE: gain=0. key=1 → RAMP_UP.
- RAMP_UP: gain +1 per step. If gain reaches 2^RAMP_BITS → ON. If key=0 → RAMP_DOWN, continuing from the current gain with no jump. If key drops on the same cycle gain reaches max, go to RAMP_DOWN.
- ON: gain=2^RAMP_BITS. key=0 → RAMP_DOWN.
- RAMP_DOWN: gain −1 per step. If gain reaches 0 → IDLE. If key=1 → RAMP_UP from the current gain. If key reasserts on the same cycle gain reaches 0, go to RAMP_UP (key has priority).
- vna_mode=1 from any state: next cycle state=ON and gain=max, with no ramp. On vna_mode falling with ptt=cw_ptt=0, the normal RAMP_DOWN applies.
- Datapath:
  - stage 1: p = (rf_in × gain) >>> RAMP_BITS, held in IN_WIDTH+1 bits.
  - stage 2: s = p >>> HEADROOM, saturated to [−2^(DAC_WIDTH−1), 2^(DAC_WIDTH−1)−1].
  - gain=max passes rf_in exactly; gain=0 yields exactly 0.
- tx_active = (state != IDLE).
- led: free-running 27-bit counter; counter[LED_FAST_BIT] when tx_active, else counter[LED_SLOW_BIT].

## Timing
- Reset: state=IDLE, gain=0, divider=0, dac_data=0, tx_active=0, led=0, counter=0. A reset asserted mid-ramp zeroes dac_data asynchronously.
- Key to state: key sampled at edge n gives the new state at n+1. The first gain step lands RAMP_DIV clocks after entry.
- A full ramp takes 2^RAMP_BITS × RAMP_DIV clocks in each direction.
- rf_in/gain to dac_data latency: 2 clocks. Gain used is the registered value at the stage-1 edge.
- No handshake: one sample per clock, continuous.

## Configuration
- TX_HANG_EN defined:
  - After RAMP_DOWN reaches IDLE, tx_active stays 1 for HANG_CYCLES clocks while dac_data=0.
  - key during the hang enters RAMP_UP and the hang counter clears.
  - Hang expiry → tx_active=0.
  - Reset clears the hang.
- TX_HANG_EN undefined: tx_active = (state != IDLE) exactly, and the HANG_CYCLES parameter is ignored.

## Test plan
Bench parameters: RAMP_BITS=4, RAMP_DIV=2, IN_WIDTH=16, DAC_WIDTH=12, HEADROOM=3.
- Basic keying with rf_in=+8000: ptt 0→1 → state=1 next cycle; gain 0→16 in 32 clocks; state=2. dac_data saturates at +2047 once scaled ≥2048, so at gain=16 dac_data=+1000.
- Saturation limits at gain=max:
  - rf_in=+32767 → dac_data=+2047.
  - rf_in=−32768 → dac_data=−2048 (no wrap).
  - rf_in=0 → dac_data=0.
- Ramp reversal: ptt dropped at gain=7 during RAMP_UP → state=3 and gain 7→6 after 2 clocks. ptt reasserted at gain=3 → state=1 and gain climbs from 3.
- VNA bypass: vna_mode=1 from IDLE → state=2 and gain=16 next cycle. vna_mode=0 → 32-clock ramp down to IDLE.
- Reset asserted mid-ramp at gain=9:
  - dac_data=0, state=0, tx_active=0 immediately.
  - After release, stays IDLE until a key is asserted.
- Hang, with TX_HANG_EN and HANG_CYCLES=10:
  - tx_active stays 1 for 10 clocks after state=0, then falls.
  - Re-key at hang clock 5 → state=1 with tx_active never deasserting.

Source files
------------

// File: rtl/tx_envelope_sequencer_if.sv
// Sample/key bundle between the upconverter side and the DAC output stage.
// master drives RF and keying inputs; slave (the sequencer) returns DAC word and status.
interface tx_envelope_sequencer_if #(
  parameter int IN_WIDTH  = 16,
  parameter int DAC_WIDTH = 12,
  parameter int RAMP_BITS = 8
);
  logic signed [IN_WIDTH-1:0]  rf_in;
  logic                        ptt;
  logic                        cw_ptt;
  logic                        vna_mode;
  logic signed [DAC_WIDTH-1:0] dac_data;
  logic                        tx_active;
  logic [1:0]                  state;
  logic [RAMP_BITS:0]          gain;
  logic                        led;

  modport master (
    output rf_in, ptt, cw_ptt, vna_mode,
    input  dac_data, tx_active, state, gain, led
  );
  modport slave (
    input  rf_in, ptt, cw_ptt, vna_mode,
    output dac_data, tx_active, state, gain, led
  );
endinterface

// File: rtl/tx_envelope_sequencer.sv
// TX keying sequencer: linear amplitude ramp, saturating narrow to DAC, T/R and heartbeat.
// Optional T/R hang after ramp-down is enabled by defining TX_HANG_EN.
module tx_envelope_sequencer #(
  parameter int IN_WIDTH     = 16,
  parameter int DAC_WIDTH    = 12,
  parameter int HEADROOM     = 3,
  parameter int RAMP_BITS    = 8,
  parameter int RAMP_DIV     = 16,
  parameter int HANG_CYCLES  = 4800,
  parameter int LED_FAST_BIT = 24,
  parameter int LED_SLOW_BIT = 26
) (
  input  logic                     clk,
  input  logic                     reset,
  tx_envelope_sequencer_if.slave   io
);
  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int PW    = IN_WIDTH + RAMP_BITS + 2;
  localparam logic [RAMP_BITS:0] GMAX = (RAMP_BITS+1)'(1 << RAMP_BITS);
  localparam logic signed [IN_WIDTH:0] SAT_HI = (IN_WIDTH+1)'((1 << (DAC_WIDTH-1)) - 1);
  localparam logic signed [IN_WIDTH:0] SAT_LO = (IN_WIDTH+1)'(-(1 << (DAC_WIDTH-1)));

  typedef enum logic [1:0] {IDLE = 2'd0, RAMP_UP = 2'd1, ON = 2'd2, RAMP_DOWN = 2'd3} st_t;

  st_t                         r_state, w_state_nx;
  logic [RAMP_BITS:0]          r_gain, w_gain_nx;
  logic [DIV_W-1:0]            r_div, w_div_nx;
  logic [26:0]                 r_cnt;
  logic signed [IN_WIDTH:0]    r_p;
  logic signed [DAC_WIDTH-1:0] r_dac;
  logic                        w_key, w_step, w_tx;
  logic signed [PW-1:0]        w_rf_x, w_g_x, w_prod;
  logic signed [IN_WIDTH:0]    w_s;

  assign w_key  = io.ptt | io.cw_ptt | io.vna_mode;
  assign w_step = (r_div == DIV_W'(RAMP_DIV - 1));

  // On a key change the gain holds for that cycle; the ramp resumes from it after a full divider period.
  always_comb begin
    w_state_nx = r_state;
    w_gain_nx  = r_gain;
    w_div_nx   = '0;
    if (io.vna_mode) begin
      w_state_nx = ON;
      w_gain_nx  = GMAX;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_gain_nx = '0;
          if (w_key) w_state_nx = RAMP_UP;
        end
        RAMP_UP: begin
          if (!w_key) w_state_nx = RAMP_DOWN;
          else if (w_step) begin
            w_gain_nx = r_gain + 1'b1;
            if (r_gain + 1'b1 == GMAX) w_state_nx = ON;
          end
        end
        ON: begin
          w_gain_nx = GMAX;
          if (!w_key) w_state_nx = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (w_key) w_state_nx = RAMP_UP;
          else if (w_step) begin
            w_gain_nx = r_gain - 1'b1;
            if (r_gain == (RAMP_BITS+1)'(1)) w_state_nx = IDLE;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
    if (w_state_nx == r_state && (r_state == RAMP_UP || r_state == RAMP_DOWN))
      w_div_nx = w_step ? '0 : r_div + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_gain  <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gain  <= w_gain_nx;
      r_div   <= w_div_nx;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Gain is unsigned; zero-extend before the signed multiply so max gain passes rf_in exactly.
  assign w_rf_x = PW'($signed(io.rf_in));
  assign w_g_x  = PW'({1'b0, r_gain});
  assign w_prod = w_rf_x * w_g_x;
  assign w_s    = r_p >>> HEADROOM;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p   <= '0;
      r_dac <= '0;
    end else begin
      r_p <= (IN_WIDTH+1)'(w_prod >>> RAMP_BITS);
      if (w_s > SAT_HI)      r_dac <= DAC_WIDTH'(SAT_HI);
      else if (w_s < SAT_LO) r_dac <= DAC_WIDTH'(SAT_LO);
      else                   r_dac <= DAC_WIDTH'(w_s);
    end
  end

`ifdef TX_HANG_EN
  localparam int HANG_W = (HANG_CYCLES > 0) ? $clog2(HANG_CYCLES + 1) : 1;
  logic [HANG_W-1:0] r_hang;

  // Hang loads on the ramp-down exit and is cancelled by any re-key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        r_hang <= '0;
    else if (r_state == RAMP_DOWN && w_state_nx == IDLE) r_hang <= HANG_W'(HANG_CYCLES);
    else if (w_state_nx != IDLE)                      r_hang <= '0;
    else if (r_hang != '0)                            r_hang <= r_hang - 1'b1;
  end
  assign w_tx = (r_state != IDLE) || (r_hang != '0);
`else
  assign w_tx = (r_state != IDLE);
`endif

  assign io.dac_data  = r_dac;
  assign io.tx_active = w_tx;
  assign io.state     = r_state;
  assign io.gain      = r_gain;
  assign io.led       = w_tx ? r_cnt[LED_FAST_BIT] : r_cnt[LED_SLOW_BIT];
endmodule

// File: tb/tb_tx_envelope_sequencer.sv
// Bench for tx_envelope_sequencer: keying/ramp sequences plus a table of saturation vectors.
module tb_tx_envelope_sequencer;
  localparam int IW = 16, DW = 12, RB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic signed [IW-1:0] rf;
    int                   exp_dac;
  } vec_t;
  vec_t vecs[12];
  int   exp_q[$];

  tx_envelope_sequencer_if #(.IN_WIDTH(IW), .DAC_WIDTH(DW), .RAMP_BITS(RB)) bus();

  tx_envelope_sequencer #(
    .IN_WIDTH(IW), .DAC_WIDTH(DW), .HEADROOM(3), .RAMP_BITS(RB), .RAMP_DIV(2),
    .HANG_CYCLES(10), .LED_FAST_BIT(24), .LED_SLOW_BIT(26)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_sg(input string nm, input int st, input int g);
    chk({nm, "_state"}, int'(bus.state), st);
    chk({nm, "_gain"}, int'(bus.gain), g);
  endtask

  initial begin
    int d;
    vecs[0]  = '{16'sd32767,  2047};
    vecs[1]  = '{-16'sd32768, -2048};
    vecs[2]  = '{16'sd0,      0};
    vecs[3]  = '{16'sd8000,   1000};
    vecs[4]  = '{-16'sd8000,  -1000};
    vecs[5]  = '{16'sd16383,  2047};
    vecs[6]  = '{16'sd16384,  2047};
    vecs[7]  = '{-16'sd16384, -2048};
    vecs[8]  = '{-16'sd16385, -2048};
    vecs[9]  = '{16'sd7,      0};
    vecs[10] = '{-16'sd1,     -1};
    vecs[11] = '{-16'sd100,   -13};

    bus.rf_in = '0; bus.ptt = 0; bus.cw_ptt = 0; bus.vna_mode = 0;
    tick(3);
    chk_sg("rst", 0, 0);
    chk("rst_dac", int'(bus.dac_data), 0);
    chk("rst_tx", int'(bus.tx_active), 0);
    chk("rst_led", int'(bus.led), 0);

    reset = 0;
    bus.rf_in = 16'sd8000;
    tick(3);
    chk_sg("idle", 0, 0);
    chk("idle_dac", int'(bus.dac_data), 0);

    // basic keying: 32-clock ramp up
    bus.ptt = 1;
    tick();
    chk_sg("key", 1, 0);
    chk("key_tx", int'(bus.tx_active), 1);
    tick(2);
    chk_sg("first_step", 1, 1);
    tick(29);
    chk_sg("up31", 1, 15);
    tick();
    chk_sg("up32", 2, 16);
    tick(2);
    chk("on_dac", int'(bus.dac_data), 1000);

    // saturation vectors at full gain through a latency-2 scoreboard
    foreach (vecs[k]) begin
      bus.rf_in = vecs[k].rf;
      exp_q.push_back(vecs[k].exp_dac);
      tick();
      if (exp_q.size() >= 2) begin
        d = exp_q.pop_front();
        chk($sformatf("sat%0d", total), int'(bus.dac_data), d);
      end
    end
    tick();
    if (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      chk("sat_last", int'(bus.dac_data), d);
    end

    // 32-clock ramp down to idle
    bus.rf_in = 16'sd8000;
    bus.ptt = 0;
    tick();
    chk_sg("dn", 3, 16);
    tick(31);
    chk_sg("dn31", 3, 1);
    tick();
    chk_sg("dn32", 0, 0);
`ifdef TX_HANG_EN
    chk("hang_start_tx", int'(bus.tx_active), 1);
    tick(9);
    chk("hang_end_tx", int'(bus.tx_active), 1);
    tick();
    chk("hang_expire_tx", int'(bus.tx_active), 0);
`else
    chk("idle_tx", int'(bus.tx_active), 0);
    tick(2);
`endif

    // ramp reversal both ways
    bus.ptt = 1;
    tick();
    chk_sg("rev_key", 1, 0);
    tick(14);
    chk_sg("rev_g7", 1, 7);
    bus.ptt = 0;
    tick();
    chk_sg("rev_drop", 3, 7);
    tick(2);
    chk_sg("rev_g6", 3, 6);
    tick(6);
    chk_sg("rev_g3", 3, 3);
    bus.ptt = 1;
    tick();
    chk_sg("rev_rekey", 1, 3);
    tick(2);
    chk_sg("rev_g4", 1, 4);
    tick(10);
    chk_sg("rev_g9", 1, 9);
    chk("ramp_dac", int'(bus.dac_data), 500);

    // asynchronous reset mid-ramp
    #2 reset = 1;
    bus.ptt = 0;
    #1;
    chk("mrst_dac", int'(bus.dac_data), 0);
    chk_sg("mrst", 0, 0);
    chk("mrst_tx", int'(bus.tx_active), 0);
    tick(2);
    reset = 0;
    tick(5);
    chk_sg("post_rst", 0, 0);
    chk("post_rst_tx", int'(bus.tx_active), 0);

    // VNA bypass and normal ramp down afterwards
    bus.vna_mode = 1;
    tick();
    chk_sg("vna", 2, 16);
    tick(3);
    bus.vna_mode = 0;
    tick();
    chk_sg("vna_off", 3, 16);
    tick(31);
    chk_sg("vna_dn31", 3, 1);
    tick();
    chk_sg("vna_dn32", 0, 0);

`ifdef TX_HANG_EN
    tick(4);
    chk("rekey_hang_tx", int'(bus.tx_active), 1);
    bus.cw_ptt = 1;
    tick();
    chk_sg("rekey_hang", 1, 0);
    chk("rekey_hang_tx2", int'(bus.tx_active), 1);
`else
    bus.cw_ptt = 1;
    tick();
    chk_sg("cw_key", 1, 0);
    chk("cw_key_tx", int'(bus.tx_active), 1);
`endif
    chk("led_tx", int'(bus.led), 0);
    bus.cw_ptt = 0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
